out_ser: RTL
============

Name: out_ser

Overview:
- Parallel-to-serial output stage sitting directly upstream of the registered output cell.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per programmable bit period.
- Drives the output cell's data, load-enable and force-high controls: ser_data feeds dataIn, ser_sel feeds sel, ser_hold feeds hold.
- Parks the line at its idle level between words.

Parameters:
- WIDTH, 8, word width in bits (>=2).
- DIV_W, 8, width of the bit-period divider input.
- LSB_FIRST, 1, 1 = shift LSB first, 0 = MSB first.
- IDLE_HIGH, 1, 1 = assert ser_hold while idle (line parked high), 0 = never assert ser_hold.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- div  in  DIV_W  bit period minus 1, in clk cycles; sampled only at word accept.
- in_data  in  WIDTH  parallel word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle (combinational).
- ser_data  out  1  serial bit to output cell dataIn.
- ser_sel  out  1  load strobe to output cell sel.
- ser_hold  out  1  force-high request to output cell hold.
- busy  out  1  word in flight.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Registers: state (IDLE/SHIFT), sreg[WIDTH], bit_cnt (0..WIDTH-1), div_cnt[DIV_W], div_lat[DIV_W].
- Registered outputs: ser_data, ser_sel, ser_hold, busy.
- Reset (rst high at an edge):
  - state=IDLE, all counters 0.
  - ser_data=0, ser_sel=0, ser_hold=0, busy=0.
  - in_ready forced 0 while rst high.
  - Reset wins over every other event, including a handshake or a mid-word shift. The word in flight is dropped.
- in_ready = !rst && (state==IDLE || (state==SHIFT && div_cnt==0 && bit_cnt==WIDTH-1)).
- Accept edge: in_valid && in_ready.
  - sreg<=in_data; div_lat<=div; div_cnt<=div; bit_cnt<=0; state<=SHIFT.
  - ser_data<=first bit (in_data[0] if LSB_FIRST else in_data[WIDTH-1]).
  - ser_sel<=1; ser_hold<=0; busy<=1.
- SHIFT, div_cnt!=0: div_cnt decrements; ser_sel<=0; ser_data is held.
- SHIFT, div_cnt==0, bit_cnt<WIDTH-1:
  - bit_cnt++; div_cnt<=div_lat.
  - sreg shifts toward the active end.
  - ser_data<=next bit; ser_sel<=1.
- SHIFT, div_cnt==0, bit_cnt==WIDTH-1 (last cycle of the last bit):
  - If in_valid: accept the new word as above. There are zero idle cycles between words and ser_hold stays 0.
  - Otherwise: state<=IDLE; busy<=0; ser_sel<=0; ser_hold<=IDLE_HIGH; ser_data keeps its last value.
- IDLE without handshake: ser_sel=0, ser_hold=IDLE_HIGH, busy=0.
  - The first idle cycle after reset release sets ser_hold<=IDLE_HIGH at that edge.
- Timing:
  - Each bit lasts div_lat+1 cycles.
  - ser_sel is a one-cycle pulse aligned with the first cycle of each bit. With div=0, ser_sel stays high for the whole word.
  - Word latency: accept edge to first bit on ser_data is 1 edge. Total busy time is WIDTH*(div_lat+1) cycles.
- div changes while busy: ignored until the next accept.
- in_data changes while not handshaking: ignored.
- No width overflow: bit_cnt is sized ceil(log2(WIDTH)) and never exceeds WIDTH-1.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, all outputs 0, nothing accepted. After release, next edge gives ser_hold=1 (IDLE_HIGH=1), in_ready=1, busy=0.
2. WIDTH=8, div=0, in_data=0xA5, LSB_FIRST=1 -> ser_data=1,0,1,0,0,1,0,1 on 8 consecutive cycles, ser_sel=1 all 8 cycles, busy 8 cycles. Then ser_hold=1, ser_sel=0.
3. div=3, in_data=0x81 -> each bit held 4 cycles, ser_sel pulses every 4th cycle (8 pulses), busy 32 cycles, ser_data high only in cycles 0-3 and 28-31.
4. Back-to-back: div=0, in_valid held high with 0x0F then 0xF0 -> second word accepted on the last-bit cycle of the first. Result is 16 contiguous bits 1111000000001111, ser_hold never 1 in between.
5. Reset mid-word: div=1, word 0xFF, rst pulsed at bit 3 -> next edge all outputs 0, word dropped. Word 0x01 sent afterward starts from bit 0 (ser_data=1 first, then 0s).
6. div changed 1->5 mid-word, plus LSB_FIRST=0 with 0x80 -> current word keeps 2-cycle bits. Next word uses 6-cycle bits, MSB first: ser_data=1 for the first 6 cycles, then 0.

Source files
------------

// File: rtl/out_ser.sv
// rtl/out_ser.sv - parallel-to-serial stage driving the registered output cell
// Words shift out one bit per (div+1) clocks; the line parks at its idle level between words.
module out_ser #(
  parameter int WIDTH     = 8,
  parameter int DIV_W     = 8,
  parameter int LSB_FIRST = 1,
  parameter int IDLE_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_sel,
  output logic             ser_hold,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]   div_lat_q, div_lat_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_sel_q, ser_sel_d;
  logic               ser_hold_q, ser_hold_d;
  logic               busy_q, busy_d;
  logic               last_cycle;
  logic               accept;

  // Ready also on the final cycle of the last bit so words chain with no gap
  assign last_cycle = (state_q == SHIFT) && (div_cnt_q == '0) && (bit_cnt_q == LAST_BIT);
  assign in_ready   = !rst && ((state_q == IDLE) || last_cycle);
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    div_lat_d  = div_lat_q;
    ser_data_d = ser_data_q;
    ser_sel_d  = 1'b0;
    ser_hold_d = ser_hold_q;
    busy_d     = busy_q;

    if (accept) begin
      state_d    = SHIFT;
      sreg_d     = in_data;
      bit_cnt_d  = '0;
      div_cnt_d  = div;
      div_lat_d  = div;
      ser_data_d = (LSB_FIRST != 0) ? in_data[0] : in_data[WIDTH-1];
      ser_sel_d  = 1'b1;
      ser_hold_d = 1'b0;
      busy_d     = 1'b1;
    end else if (state_q == SHIFT) begin
      if (div_cnt_q != '0) begin
        div_cnt_d = div_cnt_q - 1'b1;
      end else if (bit_cnt_q != LAST_BIT) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        div_cnt_d = div_lat_q;
        ser_sel_d = 1'b1;
        if (LSB_FIRST != 0) begin
          sreg_d     = {1'b0, sreg_q[WIDTH-1:1]};
          ser_data_d = sreg_q[1];
        end else begin
          sreg_d     = {sreg_q[WIDTH-2:0], 1'b0};
          ser_data_d = sreg_q[WIDTH-2];
        end
      end else begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        ser_hold_d = (IDLE_HIGH != 0);
      end
    end else begin
      busy_d     = 1'b0;
      ser_hold_d = (IDLE_HIGH != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      div_lat_q  <= '0;
      ser_data_q <= 1'b0;
      ser_sel_q  <= 1'b0;
      ser_hold_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      ser_data_q <= ser_data_d;
      ser_sel_q  <= ser_sel_d;
      ser_hold_q <= ser_hold_d;
      busy_q     <= busy_d;
    end
  end

  assign ser_data = ser_data_q;
  assign ser_sel  = ser_sel_q;
  assign ser_hold = ser_hold_q;
  assign busy     = busy_q;

endmodule
